mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- MEM stage of the 5-stage RV32I pipeline, fed by the EX/MEM register outputs.
- Performs load/store to data memory over a req/ack handshake, including byte/half/word lane steering and load sign/zero extension.
- Stalls the upstream pipeline while a memory access is outstanding.
- Selects write-back data and holds the MEM/WB pipeline register.

Parameters:
- NOP_INSTR, 32'h0000_0013, instruction value loaded on reset and on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- pc_in  in  32  PC from EX/MEM
- instruction_in  in  32  instruction from EX/MEM
- alu_result_in  in  32  ALU result (memory address for loads/stores)
- regOut_B_in  in  32  store data from EX/MEM
- RegWEn_in  in  1  register-write enable from EX/MEM
- MemRW_in  in  1  1 = store
- WBsel_in  in  2  0 = mem data, 1 = ALU, 2 = PC+4, 3 = reserved (treated as ALU)
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_wdata  out  32  lane-shifted store data
- dmem_wstrb  out  4  byte strobes
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  one-cycle completion pulse
- stall_out  out  1  freeze PC/IF/ID/EX and EX/MEM
- misalign_err  out  1  one-cycle pulse on misaligned access
- pc_MEMWB_out  out  32  MEM/WB PC
- instruction_MEMWB_out  out  32  MEM/WB instruction
- wb_data_MEMWB_out  out  32  selected write-back data
- RegWEn_MEMWB_out  out  1  MEM/WB register-write enable

Behaviour:
- Decode fields:
  - is_load = instruction_in[6:0]==7'b0000011; is_store = MemRW_in.
  - mem_op = is_load | is_store; funct3 = instruction_in[14:12].
- Misalignment check:
  - Halfword access misaligned when addr[0]=1.
  - Word access misaligned when addr[1:0]!=0.
  - A misaligned mem_op issues no request, pulses misalign_err for 1 cycle, and writes MEM/WB with RegWEn forced 0.
- FSM state IDLE:
  - Aligned mem_op: next edge latches address/we/wdata/wstrb, sets dmem_req=1, moves to WAIT. stall_out=1 this cycle.
  - Non-memory op: MEM/WB captures at the next edge (1-cycle latency), stall_out=0.
- FSM state WAIT:
  - dmem_req held at 1 and dmem_addr/we/wdata/wstrb held stable until ack.
  - stall_out = !dmem_ack.
  - On dmem_ack: capture load result into MEM/WB, drop dmem_req at next edge, return to IDLE.
- Memory-op latency is ≥2 cycles: minimum 1 stall cycle with ack in the first WAIT cycle.
- Bubbles: while stall_out=1, MEM/WB loads instruction=NOP_INSTR, RegWEn=0, wb_data=0, pc=pc_in.
- Store lanes:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 4'b0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'b1111.
  - Loads: wstrb=0, we=0.
- Load extract: byte/half selected by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Undefined load funct3 (3, 6, 7): treat as LW.
- Write-back select:
  - WBsel=0: load result.
  - WBsel=1 or 3: alu_result_in.
  - WBsel=2: pc_in+32'd4 (wraps modulo 2^32).
- Stores: RegWEn_MEMWB_out=0 regardless of RegWEn_in.
- dmem_ack outside WAIT is ignored.
- Reset, asynchronous, any state:
  - FSM→IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0.
  - stall_out=0, misalign_err=0.
  - pc/wb_data MEM/WB=0, instruction=NOP_INSTR, RegWEn=0.
  - An access in flight is abandoned; its late ack is ignored.

Decomposition:
- Shared package rv_pkg: opcode constants (OP_LOAD, OP_STORE), funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU), WBsel encodings, NOP_INSTR.
- One sub-module, lsu_lane_align: combinational store steering, strobes, load extraction/extension, and misalignment detection.
- FSM and MEM/WB register stay in the top module.

Test Plan:
- Non-memory op (ADD, WBsel=1, alu=0x1234, RegWEn=1) → next cycle wb_data=0x1234, RegWEn=1, stall_out never asserted.
- LB at addr 0x1003, ack in first WAIT cycle with rdata=0x80FF_FF00 → stall for exactly 1 cycle, dmem_addr=0x1000, wb_data=0xFFFF_FF80.
- SH at addr 0x2002 with rs2=0xABCD_1234, ack after 3 WAIT cycles → req and all dmem outputs stable for 3 cycles, wstrb=4'b1100, wdata=0x1234_1234, RegWEn_MEMWB=0.
- LW at addr 0x0001 → no dmem_req, misalign_err pulses 1 cycle, RegWEn_MEMWB=0.
- JAL with WBsel=2, pc=0xFFFF_FFFC → wb_data=0x0000_0000.
- Reset asserted in WAIT, then dmem_ack pulsed after release → dmem_req=0 immediately, FSM in IDLE, ack ignored, instruction_MEMWB=0x0000_0013.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I constants for the MEM stage: opcodes, load/store funct3 codes,
// write-back select encodings, the pipeline bubble instruction and the LSU
// FSM state type.
package rv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus.
//   dmem_req/we/addr/wdata/wstrb : request side, driven by the LSU (master)
//   dmem_rdata/dmem_ack          : response side, driven by memory (slave)
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the MEM stage.
//   funct3      : access size/sign from the instruction
//   addr_lo     : byte offset within the word
//   is_store    : store strobes/data are produced only for stores
//   store_data  : rs2 value
//   load_raw    : raw word from memory
//   wdata/wstrb : replicated store data and byte strobes
//   load_data   : extracted and extended load value
//   misaligned  : access size not aligned to addr_lo (valid for any op)
module lsu_lane_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = load_raw[7:0];
      2'd1:    byte_sel = load_raw[15:8];
      2'd2:    byte_sel = load_raw[23:16];
      default: byte_sel = load_raw[31:24];
    endcase
    half_sel = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
  end

  // Size comes from funct3[1:0]; the undefined load codes 3/6/7 land on word.
  always_comb begin
    wdata      = '0;
    wstrb      = '0;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        if (is_store) begin
          wstrb = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
      end
      2'b01: begin
        misaligned = addr_lo[0];
        if (is_store) begin
          wstrb = 4'b0011 << addr_lo;
          wdata = {2{store_data[15:0]}};
        end
      end
      default: begin
        misaligned = |addr_lo;
        if (is_store) begin
          wstrb = 4'b1111;
          wdata = store_data;
        end
      end
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = load_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage of the RV32I pipeline: issues loads/stores over the dmem req/ack
// bus, stalls upstream while an access is outstanding, selects write-back
// data and holds the MEM/WB register.
//   clk, reset            : clock, async active-high reset
//   pc_in .. WBsel_in     : EX/MEM register outputs
//   dmem                  : data-memory bus (master side)
//   stall_out             : freeze PC/IF/ID/EX and EX/MEM
//   misalign_err          : one-cycle pulse per misaligned access
//   *_MEMWB_out           : MEM/WB register
module mem_stage_lsu
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            pc_in,
  input  logic [31:0]            instruction_in,
  input  logic [31:0]            alu_result_in,
  input  logic [31:0]            regOut_B_in,
  input  logic                   RegWEn_in,
  input  logic                   MemRW_in,
  input  logic [1:0]             WBsel_in,
  mem_stage_lsu_if.master        dmem,
  output logic                   stall_out,
  output logic                   misalign_err,
  output logic [31:0]            pc_MEMWB_out,
  output logic [31:0]            instruction_MEMWB_out,
  output logic [31:0]            wb_data_MEMWB_out,
  output logic                   RegWEn_MEMWB_out
);

  logic        is_load, is_store, mem_op, misaligned;
  logic [31:0] lane_wdata, load_data, wb_sel_data;
  logic [3:0]  lane_wstrb;

  assign is_load  = (instruction_in[6:0] == OP_LOAD);
  assign is_store = MemRW_in;
  assign mem_op   = is_load | is_store;

  lsu_lane_align u_align (
    .funct3     (instruction_in[14:12]),
    .addr_lo    (alu_result_in[1:0]),
    .is_store   (is_store),
    .store_data (regOut_B_in),
    .load_raw   (dmem.dmem_rdata),
    .wdata      (lane_wdata),
    .wstrb      (lane_wstrb),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_comb begin
    case (WBsel_in)
      WB_MEM:  wb_sel_data = load_data;
      WB_PC4:  wb_sel_data = pc_in + 32'd4;
      default: wb_sel_data = alu_result_in;
    endcase
  end

  lsu_state_t  state_q, state_d;
  logic        req_q, req_d, we_q, we_d, misalign_q, misalign_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, wb_q, wb_d;
  logic        regwen_q, regwen_d;
  logic        stall, capture;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    misalign_d = 1'b0;
    stall      = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !misaligned) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {alu_result_in[31:2], 2'b00};
          wdata_d = lane_wdata;
          wstrb_d = lane_wstrb;
        end else begin
          capture    = 1'b1;
          misalign_d = mem_op;
        end
      end
      ST_WAIT: begin
        // EX/MEM is frozen while waiting, so the decode inputs still describe
        // the access in flight when the ack arrives.
        if (dmem.dmem_ack) begin
          capture = 1'b1;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pc_d = pc_in;
    if (capture) begin
      instr_d  = instruction_in;
      wb_d     = wb_sel_data;
      regwen_d = RegWEn_in & ~is_store & ~(mem_op & misaligned);
    end else begin
      instr_d  = NOP_INSTR;
      wb_d     = '0;
      regwen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      misalign_q <= 1'b0;
      pc_q       <= '0;
      instr_q    <= NOP_INSTR;
      wb_q       <= '0;
      regwen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      misalign_q <= misalign_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wb_q       <= wb_d;
      regwen_q   <= regwen_d;
    end
  end

  assign dmem.dmem_req        = req_q;
  assign dmem.dmem_we         = we_q;
  assign dmem.dmem_addr       = addr_q;
  assign dmem.dmem_wdata      = wdata_q;
  assign dmem.dmem_wstrb      = wstrb_q;
  // Stall is decoded from live EX/MEM inputs; hold it low throughout reset.
  assign stall_out             = stall & ~reset;
  assign misalign_err          = misalign_q;
  assign pc_MEMWB_out          = pc_q;
  assign instruction_MEMWB_out = instr_q;
  assign wb_data_MEMWB_out     = wb_q;
  assign RegWEn_MEMWB_out      = regwen_q;

endmodule
